boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream of the single-cycle core machine; fills instruction memory from a byte stream and holds the core in reset until the program is loaded.
- Accepts a little-endian byte stream: a 4-byte word count N, then N program words, then (optionally) a 4-byte checksum.
- Issues one instruction-memory write per assembled word, then releases core reset.
- Load is one-shot per reset.

Parameters:
- XLEN, 32, data/address width of the core; must be 32.
- MAX_WORDS, 1024, instruction memory capacity in words.
- AW, 10, word-index width; must satisfy 2^AW >= MAX_WORDS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  byte stream valid.
- s_data  in  8  byte stream data.
- s_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe, single-cycle pulse.
- imem_addr  out  XLEN  byte address of the write (word index << 2).
- imem_wdata  out  XLEN  assembled instruction word.
- core_rst  out  1  active-low reset to the core; low until DONE.
- done  out  1  load completed successfully (sticky).
- error  out  1  load failed (sticky).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low; all state clears immediately on assertion.
- Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, error=0.
- s_ready rises in the first cycle after reset deassertion.
- Byte acceptance: a byte is accepted when s_valid && s_ready.
- Byte counter (2 bits) packs bytes little-endian: byte 0 goes to bits [7:0], byte 3 to bits [31:24].
- States:
  - LEN: collect 4 bytes into count register N.
    - On the 4th byte: N==0 -> DONE; N>MAX_WORDS -> ERROR; otherwise -> LOAD with word index=0.
  - LOAD: on each 4th byte, register the word. Next cycle: imem_we=1, imem_wdata=word, imem_addr=index<<2. Index then increments.
    - After word N-1 is written: go to CSUM if the feature is enabled, else DONE.
    - s_ready stays high during the write pulse. Back-to-back bytes are allowed every cycle, so the sustained rate is 1 word per 4 cycles.
  - CSUM (feature only): collect 4 bytes, then compare against the running sum. Match -> DONE; mismatch -> ERROR.
  - DONE: s_ready=0, done=1, core_rst=1. Terminal until reset.
  - ERROR: s_ready=0, error=1, core_rst=0. Terminal until reset.
- Latency: the imem write is exactly 1 cycle after the 4th byte of a word is accepted.
- core_rst rises in the cycle after the final imem write (or after the N==0 decision, or after the checksum match).
- done and error are never both 1. No imem writes occur outside LOAD.
- s_valid with s_ready=0: the byte is ignored and not counted.
- Mid-operation reset aborts the load: partial word discarded, index=0, core held in reset. Memory contents already written are left as-is.
- Arithmetic: index is AW+1 bits to hold MAX_WORDS. imem_addr is zero-extended.

Optional Feature:
- Macro BOOT_LOADER_CHECKSUM_EN.
- Defined: a 32-bit running sum of all program words (mod 2^32, excluding N) is kept. The CSUM state is present; mismatch -> ERROR.
- Undefined: no sum register and no CSUM state; LOAD goes directly to DONE, and a trailing checksum is never consumed.

Decomposition:
- Shared package/header: XLEN; the state encoding constants S_LEN, S_LOAD, S_CSUM, S_DONE, S_ERR (3-bit).
- One natural sub-module, byte_packer: 2-bit byte counter plus a 32-bit shift/assemble register. It emits word_valid for one cycle together with the word.
- The FSM, index counter and checksum stay in boot_loader.

Test Plan:
- N=3, words 0x00500093, 0x00100113, 0x002081B3 streamed every cycle -> 3 imem_we pulses at addresses 0x0, 0x4, 0x8 with exact data. core_rst=1 and done=1 one cycle after the last pulse.
- N=0 -> no imem_we; done=1, core_rst=1 one cycle after the 4th length byte.
- N=MAX_WORDS+1 (1025) -> error=1, core_rst stays 0, s_ready=0, no writes.
- Random s_valid gaps during N=2 -> same 2 writes and data as the gapless run; bytes offered while s_ready=0 after DONE are ignored.
- rst asserted after 1.5 words of N=4 -> outputs return to reset values immediately. A fresh N=1 load then writes address 0x0 correctly.
- Feature on: N=2 with correct sum -> done=1. Same stream with sum+1 -> error=1, core_rst=0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: the core data width and the
// loader state encoding used by the top-level FSM.
package boot_loader_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_LOAD = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Byte packer: assembles four little-endian bytes into one 32-bit word.
// word_valid is raised combinationally in the cycle the fourth byte is
// accepted, together with the fully assembled word.
module boot_loader_byte_packer
  import boot_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic [7:0]      byte_data,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  logic [1:0]      cnt;
  logic [XLEN-9:0] shreg;

  // Shift each accepted byte in from the top so that the first byte ends
  // up in the least significant position once the word is complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 2'd0;
      shreg <= '0;
    end else if (accept) begin
      cnt   <= cnt + 2'd1;
      shreg <= {byte_data, shreg[XLEN-9:8]};
    end
  end

  assign word_valid = accept && (cnt == 2'd3);
  assign word       = {byte_data, shreg};

endmodule

// File: rtl/boot_loader.sv
// Boot loader: fills instruction memory from a little-endian byte stream
// (word count, program words, optional checksum) and holds the core in
// reset until the program is loaded. Load is one-shot per reset.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds a trailing 32-bit
// checksum that must match the running sum of the program words.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_rst,
  output logic            done,
  output logic            error
);

  state_t          state;
  state_t          state_nxt;
  logic [AW:0]     n_q;
  logic [AW:0]     index;
  logic            accept;
  logic            word_valid;
  logic [XLEN-1:0] word;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] sum;
`endif

  assign accept = s_valid && s_ready;

  boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .byte_data  (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register; s_ready is registered from the next state so it comes
  // up one cycle after reset release and drops as soon as a terminal
  // state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_LEN;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == S_LEN) || (state_nxt == S_LOAD) ||
                 (state_nxt == S_CSUM);
    end
  end

  // Next-state decision. The end of LOAD is taken while the last write
  // pulse is on the bus, so done follows the final write by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN: begin
        if (word_valid) begin
          if (word == '0)
            state_nxt = S_DONE;
          else if (word > XLEN'(MAX_WORDS))
            state_nxt = S_ERR;
          else
            state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (imem_we && (index == n_q)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (word_valid)
          state_nxt = (word == sum) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = state;
    endcase
  end

  // Datapath: latch the word count, issue one registered write per
  // assembled program word and advance the word index behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q        <= '0;
      index      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (state == S_LEN && word_valid) begin
        n_q   <= word[AW:0];
        index <= '0;
      end
      if (state == S_LOAD && word_valid) begin
        imem_we    <= 1'b1;
        imem_wdata <= word;
        imem_addr  <= XLEN'({index, 2'b00});
        index      <= index + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum        <= sum + word;
`endif
      end
    end
  end

  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign core_rst = (state == S_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: drives byte streams with random gaps and
// compares writes, timing and final status against a stream-level model.
// Honours BOOT_LOADER_CHECKSUM_EN the same way as the design.
module tb_boot_loader;

  localparam int MAXW = 1024;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  string cur_test = "init";

  logic [7:0]  stream[$];
  logic [31:0] wordq[$];

  // model outputs
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          consumed;
  bit          exp_done;
  bit          exp_err;
  int          final_ofs;

  // monitor state
  int          cyc = 0;
  bit          mon_clear = 1'b0;
  int          acc_cyc[$];
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  int          done_cyc;
  int          err_cyc;
  bit          both_seen;
  bit          core_bad;

  boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (mon_clear) begin
      acc_cyc.delete();
      mon_addr.delete();
      mon_data.delete();
      mon_cyc.delete();
      done_cyc  = -1;
      err_cyc   = -1;
      both_seen = 1'b0;
      core_bad  = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (imem_we) begin
        mon_addr.push_back(imem_addr);
        mon_data.push_back(imem_wdata);
        mon_cyc.push_back(cyc);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (error && err_cyc < 0) err_cyc = cyc;
      if (done && error) both_seen = 1'b1;
      if (core_rst != done) core_bad = 1'b1;
    end
  end

  // watchdog
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time (observed running, expected finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s/%s: observed 0x%08h expected 0x%08h", cur_test, tag, obs, expv);
    end
  endtask

  task automatic clearMonitor();
    @(posedge clk); #1;
    mon_clear = 1'b1;
    @(negedge clk); #1;
    mon_clear = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst     = 1'b0;
    s_valid = 1'b0;
    #1;
    checkOutput("rst_s_ready",    {31'd0, s_ready},  32'd0);
    checkOutput("rst_imem_we",    {31'd0, imem_we},  32'd0);
    checkOutput("rst_imem_addr",  imem_addr,         32'd0);
    checkOutput("rst_imem_wdata", imem_wdata,        32'd0);
    checkOutput("rst_core_rst",   {31'd0, core_rst}, 32'd0);
    checkOutput("rst_done",       {31'd0, done},     32'd0);
    checkOutput("rst_error",      {31'd0, error},    32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("ready_before_edge", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_after_release", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic fillRandomWords(input int n);
    wordq.delete();
    for (int i = 0; i < n; i++) wordq.push_back($urandom);
  endtask

  // Byte stream: length field, the words in wordq, then a checksum.
  task automatic buildStream(input logic [31:0] n_field, input bit bad_sum);
    logic [31:0] s;
    s = 32'd0;
    stream.delete();
    for (int b = 0; b < 4; b++) stream.push_back(n_field[8*b +: 8]);
    foreach (wordq[i]) begin
      for (int b = 0; b < 4; b++) stream.push_back(wordq[i][8*b +: 8]);
      s = s + wordq[i];
    end
    if (bad_sum) s = s + 32'd1;
    for (int b = 0; b < 4; b++) stream.push_back(s[8*b +: 8]);
  endtask

  // Reference model: parses the stream and predicts the write list,
  // how many bytes are taken, the outcome and the status latency.
  task automatic modelLoad();
    logic [31:0] n;
    logic [31:0] w;
    logic [31:0] s;
    logic [31:0] c;
    exp_addr.delete();
    exp_data.delete();
    n = {stream[3], stream[2], stream[1], stream[0]};
    s = 32'd0;
    final_ofs = 1;
    if (n == 0) begin
      consumed = 4; exp_done = 1'b1; exp_err = 1'b0;
    end else if (n > MAXW) begin
      consumed = 4; exp_done = 1'b0; exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]};
        exp_addr.push_back(32'(4 * i));
        exp_data.push_back(w);
        s = s + w;
      end
      consumed = 4 + 4 * int'(n);
      if (CSUM_EN) begin
        c = {stream[consumed+3], stream[consumed+2], stream[consumed+1], stream[consumed]};
        consumed = consumed + 4;
        exp_done = (c == s);
        exp_err  = (c != s);
      end else begin
        exp_done  = 1'b1;
        exp_err   = 1'b0;
        final_ofs = 2;
      end
    end
  endtask

  // Offer the first nbytes of the stream, inserting random idle gaps.
  task automatic applyStimulus(input int nbytes, input int gap_pct);
    bit ok;
    int waitc;
    int g;
    ok = 1'b1;
    for (int k = 0; k < nbytes && ok; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        g = $urandom_range(3, 1);
        repeat (g) begin
          @(posedge clk); #1;
          s_valid = 1'b0;
          s_data  = 8'($urandom);
        end
      end
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = stream[k];
      waitc   = 0;
      @(negedge clk);
      while (!s_ready && waitc < 64) begin
        @(negedge clk);
        waitc++;
      end
      if (!s_ready) begin
        checkOutput("accept_timeout", {31'd0, s_ready}, 32'd1);
        ok = 1'b0;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Full load: stimulus, stray bytes after the end, then scoreboard.
  task automatic runLoad(input string name, input int gap_pct);
    int ec;
    int last;
    cur_test = name;
    modelLoad();
    clearMonitor();
    applyStimulus(consumed, gap_pct);
    repeat (4) @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("ready_low_at_end", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("bytes_taken", acc_cyc.size(), consumed);
    checkOutput("nwrites", mon_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
      checkOutput($sformatf("addr%0d", i), mon_addr[i], exp_addr[i]);
      checkOutput($sformatf("data%0d", i), mon_data[i], exp_data[i]);
      if (4 * i + 7 < acc_cyc.size())
        checkOutput($sformatf("wcyc%0d", i), mon_cyc[i], acc_cyc[4*i+7] + 1);
    end
    checkOutput("done",     {31'd0, done},     {31'd0, exp_done});
    checkOutput("error",    {31'd0, error},    {31'd0, exp_err});
    checkOutput("core_rst", {31'd0, core_rst}, {31'd0, exp_done});
    checkOutput("never_both", {31'd0, both_seen}, 32'd0);
    checkOutput("core_rst_tracks_done", {31'd0, core_bad}, 32'd0);
    if (acc_cyc.size() >= consumed) begin
      last = acc_cyc[consumed-1];
      ec   = last + final_ofs;
      if (exp_done) begin
        checkOutput("done_cycle", done_cyc, ec);
        checkOutput("no_error_seen", err_cyc, -1);
      end else begin
        checkOutput("error_cycle", err_cyc, ec);
        checkOutput("no_done_seen", done_cyc, -1);
      end
    end
  endtask

  initial begin
    int n;
    bit bad;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;

    cur_test = "reset";
    doReset();

    // Known three-instruction program, back to back
    wordq.delete();
    wordq.push_back(32'h00500093);
    wordq.push_back(32'h00100113);
    wordq.push_back(32'h002081B3);
    buildStream(32'd3, 1'b0);
    runLoad("n3_program", 0);

    // Empty program
    cur_test = "reset";
    doReset();
    wordq.delete();
    buildStream(32'd0, 1'b0);
    runLoad("n0", 0);

    // Oversized count
    doReset();
    fillRandomWords(2);
    buildStream(32'(MAXW + 1), 1'b0);
    runLoad("n_too_big", 0);

    // Same N=2 stream with and without gaps
    doReset();
    fillRandomWords(2);
    buildStream(32'd2, 1'b0);
    runLoad("n2_gapless", 0);
    doReset();
    runLoad("n2_gaps", 50);

    // Reset mid-load after 1.5 words, then a fresh single-word load
    doReset();
    fillRandomWords(4);
    buildStream(32'd4, 1'b0);
    cur_test = "abort";
    clearMonitor();
    applyStimulus(10, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_writes_before", mon_addr.size(), 1);
    checkOutput("abort_imem_wdata", imem_wdata, 32'd0);
    checkOutput("abort_imem_addr",  imem_addr,  32'd0);
    checkOutput("abort_imem_we",    {31'd0, imem_we}, 32'd0);
    checkOutput("abort_s_ready",    {31'd0, s_ready}, 32'd0);
    checkOutput("abort_core_rst",   {31'd0, core_rst}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    fillRandomWords(1);
    buildStream(32'd1, 1'b0);
    runLoad("after_abort_n1", 0);

    // Full-capacity load
    doReset();
    fillRandomWords(MAXW);
    buildStream(32'(MAXW), 1'b0);
    runLoad("n_max", 0);

    // Random loads, random gaps, random checksum validity
    for (int r = 0; r < 6; r++) begin
      doReset();
      n   = $urandom_range(6, 1);
      bad = 1'($urandom_range(1));
      fillRandomWords(n);
      buildStream(32'(n), bad);
      runLoad($sformatf("rand%0d", r), 30);
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    doReset();
    fillRandomWords(2);
    buildStream(32'd2, 1'b0);
    runLoad("csum_good", 0);
    doReset();
    buildStream(32'd2, 1'b1);
    runLoad("csum_bad", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
